// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared state encoding and direction constants for shift_seq_ctrl
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_reg.sv
// rtl/shift_seq_reg.sv - N-bit load/shift register stepped one bit per enabled cycle
module shift_seq_reg
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         shift_en,
  input  logic         dir,
  input  logic         fill,
  output logic [N-1:0] q
);

  // load wins over shift so an accept never blends with a stale step
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_LEFT) begin
        q <= {q[N-2:0], fill};
      end else begin
        q <= {fill, q[N-1:1]};
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command-driven shift sequencer; optional rotate via SHIFT_SEQ_CTRL_ROT_EN
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_dir,
  input  logic [AW-1:0] cmd_amt,
  input  logic [N-1:0]  cmd_data,
`ifdef SHIFT_SEQ_CTRL_ROT_EN
  input  logic          cmd_rot,
`endif
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          busy
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  localparam logic [AW-1:0] N_AMT = AW'(N);

  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] amt_sat;
  logic          dir_q;
  logic          rst_q;
  logic          accept;
  logic          fill;
  logic [N-1:0]  q;

  // rst_q keeps cmd_ready low for the whole time clr is asserted
  assign cmd_ready = (state == IDLE) && !rst_q;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_data  = q;

  assign accept  = cmd_ready && cmd_valid;
  assign amt_sat = (cmd_amt > N_AMT) ? N_AMT : cmd_amt;

`ifdef SHIFT_SEQ_CTRL_ROT_EN
  logic rot_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      rot_q <= 1'b0;
    end else if (accept) begin
      rot_q <= cmd_rot;
    end
  end

  // rotate feeds the bit leaving one end back into the other
  assign fill = rot_q & ((dir_q == DIR_LEFT) ? q[N-1] : q[0]);
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= DIR_RIGHT;
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dir_q <= cmd_dir;
            cnt   <= amt_sat;
            state <= (amt_sat == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  shift_seq_reg #(
    .N(N)
  ) u_reg (
    .clk      (clk),
    .clr      (clr),
    .load     (accept),
    .load_data(cmd_data),
    .shift_en (state == SHIFT),
    .dir      (dir_q),
    .fill     (fill),
    .q        (q)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl (N=8), rotate cases under SHIFT_SEQ_CTRL_ROT_EN
module tb_shift_seq_ctrl;

  localparam int N  = 8;
  localparam int AW = $clog2(N) + 1;
`ifdef SHIFT_SEQ_CTRL_ROT_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] data;
    int           lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [AW-1:0] cmd_amt = '0;
  logic [N-1:0]  cmd_data = '0;
  logic          cmd_rot = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [N-1:0]  res_data;
  logic          busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.N(N), .AW(AW)) dut (
    .clk      (clk),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_amt  (cmd_amt),
    .cmd_data (cmd_data),
`ifdef SHIFT_SEQ_CTRL_ROT_EN
    .cmd_rot  (cmd_rot),
`endif
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [N-1:0] d, input logic dir,
                                         input int amt, input logic rot);
    int k;
    k = (amt > N) ? N : amt;
    for (int i = 0; i < k; i++) begin
      if (dir) d = {d[N-2:0], rot ? d[N-1] : 1'b0};
      else     d = {rot ? d[0] : 1'b0, d[N-1:1]};
    end
    return d;
  endfunction

  task automatic send_cmd(input logic [N-1:0] d, input logic dir, input int amt, input logic rot);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_amt   = AW'(amt);
    cmd_rot   = rot & ROT;
    e.data = model(d, dir, amt, rot & ROT);
    e.lat  = ((amt > N) ? N : amt) + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = N'($urandom);
    cmd_dir   = ~dir;
    cmd_amt   = AW'($urandom_range(0, 2 * N - 1));
    cmd_rot   = ~cmd_rot;
  endtask

  task automatic get_result(input int hold);
    exp_t         e;
    int           lat;
    logic [N-1:0] snap;
    lat = 1;
    @(negedge clk);
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("busy_done", {31'd0, busy}, 32'd1);
    snap = res_data;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_data", {24'd0, res_data}, {24'd0, snap});
      chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    chk("res_data", {24'd0, res_data}, {24'd0, e.data});
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'd0, res_valid}, 32'd0);
    chk("post_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    clr = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
    end
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data", {24'd0, res_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_ready_high", {31'd0, cmd_ready}, 32'd1);

    send_cmd(8'hB4, 1'b0, 3, 1'b0);
    get_result(5);
    send_cmd(8'hB4, 1'b1, 0, 1'b0);
    get_result(0);
    send_cmd(8'hFF, 1'b1, 12, 1'b0);
    get_result(1);
    send_cmd(8'hFF, 1'b1, 12, 1'b1);
    get_result(0);
    send_cmd(8'h81, 1'b0, 1, 1'b1);
    get_result(0);
    send_cmd(8'h81, 1'b1, 1, 1'b1);
    get_result(0);
    send_cmd(8'h5A, 1'b0, 8, 1'b0);
    get_result(0);

    // abort mid-shift: two shifts, then clr
    send_cmd(8'hC3, 1'b0, 5, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    void'(sb.pop_front());
    @(negedge clk);
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_data", {24'd0, res_data}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_result", {31'd0, res_valid}, 32'd0);
    end

    send_cmd(8'h3C, 1'b1, 2, 1'b0);
    get_result(5);

    for (int i = 0; i < 10; i++) begin
      send_cmd(N'($urandom), 1'($urandom), $urandom_range(0, 15), 1'($urandom));
      get_result($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
